scan_chain_ctrl: RTL and testbench

- Test-side driver for a scan chain of mux-scan flops with async set (SE/SI/SETB style cells).
- Serially loads a parallel pattern into the chain through SE/SI, pulses one or more functional capture clocks, then unloads the chain end (SO) into a parallel response word.
- Can also issue an active-low SETB preset pulse to the whole chain.
- Sits between the test host logic and the cell-level chain in the DFT wrapper.

---
 rtl/scan_pkg.sv | 24 ++
 rtl/scan_shift_reg.sv | 32 +++
 rtl/scan_chain_ctrl.sv | 163 ++++++++++++++++
 tb/tb_scan_chain_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and sizing helpers for the scan chain controller.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_IN,
    CAPTURE,
    SHIFT_OUT,
    DONE_ST,
    SET
  } scan_state_e;

  // Counter must reach the largest of the three phase lengths minus one.
  function automatic int unsigned cnt_width(input int unsigned chain_len,
                                            input int unsigned capture_cycles,
                                            input int unsigned set_pulse);
    int unsigned m;
    m = chain_len;
    if (capture_cycles > m) m = capture_cycles;
    if (set_pulse > m) m = set_pulse;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/scan_shift_reg.sv
// CHAIN_LEN-wide register: parallel load, right shift (LSB out first) and
// single-bit write at an index, used for both pattern and response words.
module scan_shift_reg #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  input  logic             sample,
  input  logic [IDX_W-1:0] idx,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= q >> 1;
    end else if (sample) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (idx == IDX_W'(i)) q[i] <= sin;
      end
    end
  end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain driver: serial load of a pattern, functional capture, serial
// unload into a response word, plus an active-low preset pulse.
module scan_chain_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned CHAIN_LEN      = 16,
  parameter int unsigned CAPTURE_CYCLES = 1,
  parameter int unsigned SET_PULSE      = 2,
  parameter logic        FILL_BIT       = 1'b0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 PRESET,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 SETB_N,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP_OUT
);

  localparam int unsigned CW = cnt_width(CHAIN_LEN, CAPTURE_CYCLES, SET_PULSE);
  localparam logic [CW-1:0] LEN_LAST = CW'(CHAIN_LEN - 1);
  localparam logic [CW-1:0] CAP_LAST = CW'(CAPTURE_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(SET_PULSE - 1);

  scan_state_e          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 se_n, si_n, setb_n_n, busy_n, done_n;
  logic                 pat_load, pat_shift, resp_sample, resp_publish;
  logic [CHAIN_LEN-1:0] pat_q, resp_q;

  scan_shift_reg #(.WIDTH(CHAIN_LEN), .IDX_W(CW)) u_pat (
    .clk       (CLK),
    .rst       (RST),
    .load      (pat_load),
    .load_data (PAT_IN),
    .shift     (pat_shift),
    .sample    (1'b0),
    .idx       ('0),
    .sin       (1'b0),
    .q         (pat_q)
  );

  scan_shift_reg #(.WIDTH(CHAIN_LEN), .IDX_W(CW)) u_resp (
    .clk       (CLK),
    .rst       (RST),
    .load      (1'b0),
    .load_data ('0),
    .shift     (1'b0),
    .sample    (resp_sample),
    .idx       (cnt),
    .sin       (SO),
    .q         (resp_q)
  );

  // Pin outputs are computed for the next state so they line up with it;
  // SI for the next shift cycle is the bit that the pattern shift will expose.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    se_n         = 1'b0;
    si_n         = 1'b0;
    setb_n_n     = 1'b1;
    done_n       = 1'b0;
    pat_load     = 1'b0;
    pat_shift    = 1'b0;
    resp_sample  = 1'b0;
    resp_publish = 1'b0;
    case (state)
      IDLE: begin
        if (PRESET) begin
          state_n  = SET;
          cnt_n    = '0;
          setb_n_n = 1'b0;
        end else if (START) begin
          state_n  = SHIFT_IN;
          cnt_n    = '0;
          pat_load = 1'b1;
          se_n     = 1'b1;
          si_n     = PAT_IN[0];
        end
      end
      SHIFT_IN: begin
        pat_shift = 1'b1;
        if (cnt == LEN_LAST) begin
          state_n = CAPTURE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
          se_n  = 1'b1;
          si_n  = 1'(pat_q >> 1);
        end
      end
      CAPTURE: begin
        if (cnt == CAP_LAST) begin
          state_n = SHIFT_OUT;
          cnt_n   = '0;
          se_n    = 1'b1;
          si_n    = FILL_BIT;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SHIFT_OUT: begin
        resp_sample = 1'b1;
        if (cnt == LEN_LAST) begin
          state_n = DONE_ST;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
          se_n  = 1'b1;
          si_n  = FILL_BIT;
        end
      end
      DONE_ST: begin
        done_n       = 1'b1;
        resp_publish = 1'b1;
        state_n      = IDLE;
      end
      SET: begin
        if (cnt == SET_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n    = cnt + CW'(1);
          setb_n_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      SE       <= 1'b0;
      SI       <= 1'b0;
      SETB_N   <= 1'b1;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      RESP_OUT <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      SE     <= se_n;
      SI     <= si_n;
      SETB_N <= setb_n_n;
      BUSY   <= busy_n;
      DONE   <= done_n;
      if (resp_publish) RESP_OUT <= resp_q;
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Scoreboard bench: behavioural 4-flop and 1-flop chains, expected responses
// derived from pattern and capture mode, checked when DONE pulses.
module tb_scan_chain_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, preset, so, se, si, setb_n, busy, done;
  logic [3:0] pat_in, resp_out;
  logic       start1, so1, se1, si1, setb1, busy1, done1;
  logic [0:0] pat1, resp1;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int mode  = 0;  // 0: D=Q hold, 1: D=~Q, 2: D=1

  typedef struct {
    logic [3:0] resp;
    int         acc;
  } exp_t;
  exp_t sb[$];
  exp_t sb1[$];

  logic [3:0] ch;
  logic       ch1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scan_chain_ctrl #(.CHAIN_LEN(4), .CAPTURE_CYCLES(1), .SET_PULSE(2), .FILL_BIT(1'b0)) dut (
    .CLK(clk), .RST(rst), .START(start), .PRESET(preset), .PAT_IN(pat_in), .SO(so),
    .SE(se), .SI(si), .SETB_N(setb_n), .BUSY(busy), .DONE(done), .RESP_OUT(resp_out)
  );

  scan_chain_ctrl #(.CHAIN_LEN(1), .CAPTURE_CYCLES(1), .SET_PULSE(2), .FILL_BIT(1'b0)) dut1 (
    .CLK(clk), .RST(rst), .START(start1), .PRESET(1'b0), .PAT_IN(pat1), .SO(so1),
    .SE(se1), .SI(si1), .SETB_N(setb1), .BUSY(busy1), .DONE(done1), .RESP_OUT(resp1)
  );

  // ch[3] is the first flop (fed by SI), ch[0] the last (drives SO)
  always @(posedge clk or negedge setb_n) begin
    if (!setb_n) ch <= 4'hF;
    else if (se) ch <= {si, ch[3:1]};
    else if (mode == 1) ch <= ~ch;
    else if (mode == 2) ch <= 4'hF;
  end
  assign so = ch[0];

  always @(posedge clk or negedge setb1) begin
    if (!setb1) ch1 <= 1'b1;
    else if (se1) ch1 <= si1;
  end
  assign so1 = ch1;

  function automatic logic [3:0] model(input logic [3:0] p, input int m);
    case (m)
      0:       return p;
      1:       return ~p;
      default: return 4'hF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("spurious_done", done, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_out", resp_out, e.resp);
        chk("done_latency", cyc - e.acc, 10);
      end
    end
    if (done1 === 1'b1) begin
      if (sb1.size() == 0) chk("spurious_done1", done1, 0);
      else begin
        exp_t e;
        e = sb1.pop_front();
        chk("resp_out1", resp1, e.resp);
        chk("done_latency1", cyc - e.acc, 4);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    while (busy !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy !== 1'b0) chk("idle_timeout", busy, 0);
  endtask

  task automatic do_start(input logic [3:0] p, input int m, input bit push);
    exp_t e;
    wait_idle();
    @(negedge clk);
    mode = m;
    pat_in = p;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.resp = model(p, m);
    e.acc = cyc;
    if (push) sb.push_back(e);
  endtask

  task automatic do_preset(input bit with_start);
    wait_idle();
    @(negedge clk);
    preset = 1'b1;
    start = with_start;
    pat_in = 4'($urandom);
    @(posedge clk);
    #1;
    preset = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("setb_n_low", setb_n, 0);
      chk("busy_in_set", busy, 1);
      chk("se_in_set", se, 0);
    end
    @(negedge clk);
    chk("setb_n_release", setb_n, 1);
    chk("busy_after_set", busy, 0);
  endtask

  task automatic poke_busy(input int j);
    repeat (j) @(negedge clk);
    start = 1'b1;
    preset = 1'($urandom_range(1));
    pat_in = 4'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    preset = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_se"}, se, 0);
    chk({tag, "_si"}, si, 0);
    chk({tag, "_setb_n"}, setb_n, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_resp_out"}, resp_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] p;
    exp_t e1;
    rst = 1'b1; start = 1'b0; preset = 1'b0; pat_in = '0;
    start1 = 1'b0; pat1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // directed load/unload with SE/SI sequence
    p = 4'b1011;
    do_start(p, 0, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("shift_in_se", se, 1);
      chk("shift_in_si", si, p[k]);
    end
    @(negedge clk);
    chk("capture_se", se, 0);

    do_start(4'b0110, 1, 1);

    do_preset(1'b0);
    do_start(4'b0000, 2, 1);

    // arbitration: PRESET wins, START dropped
    do_preset(1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("arb_no_shift", se, 0);
    end

    // START/PRESET while busy are ignored
    do_start(4'b1100, 0, 1);
    poke_busy(3);

    // reset in SHIFT_IN cycle k=2
    do_start(4'b0101, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midreset");
    rst = 1'b0;
    do_start(4'b1001, 0, 1);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(3) == 0) do_preset(1'($urandom_range(1)));
      do_start(4'($urandom), int'($urandom_range(2)), 1);
      if ($urandom_range(2) == 0) poke_busy(int'($urandom_range(8, 1)));
    end

    // single-flop chain
    wait_idle();
    @(negedge clk);
    pat1 = 1'b1;
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    e1.resp = 4'b0001;
    e1.acc = cyc;
    sb1.push_back(e1);

    for (int t = 0; t < 200 && (sb.size() != 0 || sb1.size() != 0); t++) @(negedge clk);
    chk("pending_expected", sb.size() + sb1.size(), 0);
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
